// File: rtl/mba_pkg.sv
// ----------------------------------------------------------------------------
// mba_pkg
// Shared definitions for the MBA memory slave: controller state encoding,
// MBA address/burst field widths and the helpers that turn a 32-bit-word
// burst request into a memory beat count and a starting beat index.
// ----------------------------------------------------------------------------
package mba_pkg;

    localparam int MBA_ADR_W  = 28;  // ARB_ADR carries byte address bits [29:2]
    localparam int MBA_BST_W  = 8;   // ARB_BST carries word count minus one
    localparam int BEAT_CNT_W = 9;   // up to 256 beats when DW = 32

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        GRANT,
        LAT,
        DATA
    } mba_state_e;

    // Number of DW-bit beats needed to carry (bst+1) 32-bit words, never zero.
    function automatic logic [BEAT_CNT_W-1:0] beat_count(
        input logic [MBA_BST_W-1:0] bst,
        input int                   dw
    );
        int bytes_total;
        int bytes_beat;
        int n;
        bytes_total = (int'(bst) + 1) * 4;
        bytes_beat  = dw / 8;
        n           = (bytes_total + bytes_beat - 1) / bytes_beat;
        if (n < 1) n = 1;
        return n[BEAT_CNT_W-1:0];
    endfunction

    // Word address to beat address: drop the word bits that fall inside a beat.
    function automatic logic [MBA_ADR_W-1:0] word_to_beat(
        input logic [MBA_ADR_W-1:0] adr,
        input int                   dw
    );
        int sh;
        case (dw)
            64:      sh = 1;
            128:     sh = 2;
            256:     sh = 3;
            default: sh = 0;
        endcase
        return adr >> sh;
    endfunction

endpackage

// File: rtl/mba_mem_slv_crc32.sv
// ----------------------------------------------------------------------------
// mba_mem_slv_crc32
// Galois CRC-32 style LFSR (polynomial 0x04C11DB7) that shifts one bit per
// clock with a serial input folded into the feedback.
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset, loads INIT
//   din  in   serial input bit mixed into the feedback
//   crc  out  current LFSR state
// ----------------------------------------------------------------------------
module mba_mem_slv_crc32 #(
    parameter int           W    = 32,
    parameter logic [W-1:0] INIT = '1,
    parameter logic [W-1:0] POLY = 32'h04C1_1DB7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    output logic [W-1:0] crc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= INIT;
        end else begin
            crc <= {crc[W-2:0], 1'b0} ^ ({W{crc[W-1] ^ din}} & POLY);
        end
    end

endmodule

// File: rtl/mba_mem_slv.sv
// ----------------------------------------------------------------------------
// mba_mem_slv
// MBA bus memory slave model: a 2^AW x DW memory behind the MBA arbitration
// handshake, with fixed or LFSR-randomised grant and data-start latency.
// After every reset the memory is zero-filled one beat per cycle before the
// slave reports idle.
//   CLK      in   clock, rising edge
//   RESET    in   synchronous active-high reset
//   ARB_REQ  in   request, active-low, held until ARB_REL
//   ARB_REL  out  one-cycle request acknowledge
//   ARB_NEL  out  high while idle and able to accept a request
//   ARB_RZW  in   0 = write burst, 1 = read burst
//   ARB_ADR  in   32-bit-word start address
//   ARB_BST  in   burst length in 32-bit words minus one
//   ARB_WAK  out  write data strobe, active-low
//   ARB_RDT  in   write data
//   ARB_BEN  in   write byte enables, active-low
//   ARB_RAK  out  read data strobe, active-low
//   ARB_WDT  out  read data, zero outside read beats
//   ERR      out  sticky: a burst wrapped past the top of memory
// ----------------------------------------------------------------------------
module mba_mem_slv
    import mba_pkg::*;
#(
    parameter int          DW        = 128,
    parameter int          AW        = 8,
    parameter int          RAND_EN   = 0,
    parameter int          GNT_DLY   = 2,
    parameter int          DATA_DLY  = 3,
    parameter logic [31:0] LFSR_INIT = 32'hFFFF_FFFF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ARB_REQ,
    output logic                 ARB_REL,
    output logic                 ARB_NEL,
    input  logic                 ARB_RZW,
    input  logic [MBA_ADR_W-1:0] ARB_ADR,
    input  logic [MBA_BST_W-1:0] ARB_BST,
    output logic                 ARB_WAK,
    input  logic [DW-1:0]        ARB_RDT,
    input  logic [DW/8-1:0]      ARB_BEN,
    output logic                 ARB_RAK,
    output logic [DW-1:0]        ARB_WDT,
    output logic                 ERR
);

    localparam int                    NB         = DW / 8;
    localparam logic [AW-1:0]         IDX_MAX    = '1;
    localparam logic [3:0]            GNT_DLY_C  = 4'(GNT_DLY);
    localparam logic [3:0]            LAT_END_C  = 4'(DATA_DLY - 1);
    localparam logic [BEAT_CNT_W-1:0] BEAT_ONE   = BEAT_CNT_W'(1);

    mba_state_e            state;
    mba_state_e            state_nx;
    logic [AW-1:0]         idx;         // clear pointer in CLEAR, beat index otherwise
    logic [AW-1:0]         rd_idx;
    logic [BEAT_CNT_W-1:0] beats_left;
    logic [3:0]            cnt;         // edges spent in the current state, saturating
    logic                  rzw;
    logic                  err;
    logic                  gnt_ok;
    logic                  lat_ok;
    logic [31:0]           lfsr;
    logic                  lfsr_unused;
    logic [DW-1:0]         rdata;
    logic [DW-1:0]         mem [0:(1<<AW)-1];

    mba_mem_slv_crc32 #(
        .W    (32),
        .INIT (LFSR_INIT)
    ) u_lfsr (
        .clk (CLK),
        .rst (RESET),
        .din (~ARB_REQ),
        .crc (lfsr)
    );

    // Only the low taps gate grant and data start.
    assign lfsr_unused = ^lfsr[31:4];

    always_comb begin
        state_nx = state;
        ARB_REL  = 1'b0;
        gnt_ok   = (cnt >= GNT_DLY_C) && ((RAND_EN == 0) || (lfsr[1:0] == 2'b11));
        // Decided one cycle ahead so the first beat lands DATA_DLY cycles after capture.
        lat_ok   = (cnt >= LAT_END_C) && ((RAND_EN == 0) || (lfsr[3:2] == 2'b11));
        case (state)
            CLEAR: if (idx == IDX_MAX) state_nx = IDLE;
            IDLE:  if (!ARB_REQ) state_nx = GRANT;
            GRANT: begin
                if (gnt_ok) begin
                    ARB_REL  = 1'b1;
                    state_nx = ARB_REQ ? IDLE : LAT;
                end
            end
            LAT:   if (lat_ok) state_nx = DATA;
            DATA:  if (beats_left == BEAT_ONE) state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= CLEAR;
            idx        <= '0;
            cnt        <= '0;
            beats_left <= '0;
            rzw        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if (cnt != 4'hF) begin
                cnt <= cnt + 4'd1;
            end
            case (state)
                CLEAR: idx <= idx + 1'b1;
                GRANT: begin
                    if (ARB_REL && !ARB_REQ) begin
                        rzw        <= ARB_RZW;
                        idx        <= AW'(word_to_beat(ARB_ADR, DW));
                        beats_left <= beat_count(ARB_BST, DW);
                    end
                end
                DATA: begin
                    idx        <= idx + 1'b1;
                    beats_left <= beats_left - BEAT_ONE;
                    if (idx == IDX_MAX && beats_left > BEAT_ONE) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read data is fetched one cycle ahead: the start beat during the last LAT
    // cycle, then the following index during each read beat.
    assign rd_idx = (state == DATA) ? idx + 1'b1 : idx;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == CLEAR) begin
                mem[idx] <= '0;
            end else if (state == DATA && !rzw) begin
                for (int b = 0; b < NB; b++) begin
                    if (!ARB_BEN[b]) mem[idx][8*b +: 8] <= ARB_RDT[8*b +: 8];
                end
            end
        end
        rdata <= mem[rd_idx];
    end

    assign ARB_NEL = (state == IDLE);
    assign ARB_WAK = !(state == DATA && !rzw);
    assign ARB_RAK = !(state == DATA && rzw);
    assign ARB_WDT = ARB_RAK ? '0 : rdata;
    assign ERR     = err;

endmodule
